// File: rtl/rx_iod_multilane_bit_align.sv
// Multi-lane IOD bit-alignment trainer: sweeps each lane's tap range and parks it at the centre of its widest clean window.
// Optional macro RX_ALGN_TRACK_EN adds continuous +/-2 tap tracking of passing lanes while in DONE.
module rx_iod_multilane_bit_align #(
  parameter int unsigned NUM_LANES          = 4,
  parameter int unsigned TAP_CNT_WIDTH      = 8,
  parameter int unsigned TAP_WAIT_CNT_WIDTH = 3,
  parameter int unsigned MIN_WINDOW         = 10
) (
  input  logic                                SCLK,
  input  logic                                RESET,
  input  logic                                PLL_LOCK,
  input  logic                                ALGN_RSTRT,
  input  logic                                ALGN_HOLD,
  input  logic                                ALGN_SKIP,
  input  logic [NUM_LANES-1:0]                IOD_EARLY,
  input  logic [NUM_LANES-1:0]                IOD_LATE,
  input  logic [NUM_LANES-1:0]                IOD_OOR,
  output logic [NUM_LANES-1:0]                ALGN_CLR_FLGS,
  output logic [NUM_LANES-1:0]                ALGN_LOAD,
  output logic [NUM_LANES-1:0]                ALGN_MOVE,
  output logic [NUM_LANES-1:0]                ALGN_DIR,
  output logic [NUM_LANES*TAP_CNT_WIDTH-1:0]  LANE_TAPDLY,
  output logic                                ALGN_START,
  output logic                                ALGN_DONE,
  output logic                                ALGN_ERR,
  output logic [NUM_LANES-1:0]                ALGN_ERR_LANE,
  output logic                                ALGN_OOR
);

  localparam int unsigned W  = TAP_CNT_WIDTH;
  localparam int unsigned WW = TAP_CNT_WIDTH + 1;
  localparam int unsigned SW = TAP_WAIT_CNT_WIDTH;
  localparam int unsigned LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [W-1:0]  TAP_MAX = '1;
  localparam logic [WW-1:0] MIN_WIN = WW'(MIN_WINDOW);
  localparam logic [LW-1:0] LAST_LANE = LW'(NUM_LANES - 1);

  typedef enum logic [3:0] {
    ST_WAIT_LOCK, ST_LOAD, ST_CLR, ST_SETTLE, ST_SAMPLE,
    ST_STEP, ST_CENTER, ST_NEXT_LANE, ST_DONE
  } state_t;

  state_t                      state_q, state_d;
  logic [LW-1:0]               lane_q, lane_d;
  logic                        lock_q, lock_d;
  logic [SW-1:0]               wait_q, wait_d;
  logic [NUM_LANES-1:0][W-1:0] tap_q, tap_d;
  logic [W-1:0]                cur_start_q, cur_start_d, best_start_q, best_start_d;
  logic [WW-1:0]               cur_len_q, cur_len_d, best_len_q, best_len_d;
  logic [NUM_LANES-1:0]        clr_q, clr_d, load_q, load_d, move_q, move_d, dir_q, dir_d;
  logic [NUM_LANES-1:0]        err_lane_q, err_lane_d;
  logic                        oor_q, oor_d, start_q, start_d, done_q, done_d, err_q, err_d;
`ifdef RX_ALGN_TRACK_EN
  logic [NUM_LANES-1:0][W-1:0] center_q, center_d;
  logic [LW-1:0]               trk_lane_q, trk_lane_d;
  logic [1:0]                  trk_ph_q, trk_ph_d;
`endif

  // Next-state and next-output logic; lock loss beats hold, hold beats everything else.
  always_comb begin
    logic [W-1:0]  target;
    logic [W-1:0]  cs;
    logic [WW-1:0] cl;
`ifdef RX_ALGN_TRACK_EN
    logic [LW-1:0] idx, nl;
    logic          found;
    logic [WW-1:0] t_ext, c_ext;
`endif
    state_d      = state_q;
    lane_d       = lane_q;
    lock_d       = PLL_LOCK;
    wait_d       = wait_q;
    tap_d        = tap_q;
    cur_start_d  = cur_start_q;
    cur_len_d    = cur_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    clr_d        = '0;
    load_d       = '0;
    move_d       = '0;
    dir_d        = dir_q;
    err_lane_d   = err_lane_q;
    oor_d        = oor_q;
    target       = best_start_q + W'((best_len_q - WW'(1)) >> 1);
    cs           = cur_start_q;
    cl           = cur_len_q;
`ifdef RX_ALGN_TRACK_EN
    center_d     = center_q;
    trk_lane_d   = trk_lane_q;
    trk_ph_d     = trk_ph_q;
    idx          = trk_lane_q;
    nl           = trk_lane_q;
    found        = 1'b0;
    t_ext        = {1'b0, tap_q[trk_lane_q]};
    c_ext        = {1'b0, center_q[trk_lane_q]};
`endif

    if (!PLL_LOCK && (state_q != ST_WAIT_LOCK)) begin
      state_d      = ST_WAIT_LOCK;
      lane_d       = '0;
      lock_d       = 1'b0;
      wait_d       = '0;
      cur_start_d  = '0;
      cur_len_d    = '0;
      best_start_d = '0;
      best_len_d   = '0;
      dir_d        = '0;
      err_lane_d   = '0;
      oor_d        = 1'b0;
`ifdef RX_ALGN_TRACK_EN
      center_d     = '0;
      trk_lane_d   = LAST_LANE;
      trk_ph_d     = '0;
`endif
    end else if (ALGN_HOLD) begin
      lock_d = lock_q;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          if (PLL_LOCK && lock_q) begin
            lane_d  = '0;
            state_d = ALGN_SKIP ? ST_DONE : ST_LOAD;
          end
        end
        ST_LOAD: begin
          load_d[lane_q] = 1'b1;
          tap_d[lane_q]  = '0;
          cur_start_d    = '0;
          cur_len_d      = '0;
          best_start_d   = '0;
          best_len_d     = '0;
          state_d        = ST_CLR;
        end
        ST_CLR: begin
          clr_d[lane_q] = 1'b1;
          wait_d        = '0;
          state_d       = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (wait_q == '1) state_d = ST_SAMPLE;
          else              wait_d  = wait_q + SW'(1);
        end
        ST_SAMPLE: begin
          if (!IOD_EARLY[lane_q] && !IOD_LATE[lane_q]) begin
            cs          = (cur_len_q == '0) ? tap_q[lane_q] : cur_start_q;
            cl          = cur_len_q + WW'(1);
            cur_start_d = cs;
            cur_len_d   = cl;
            // strict compare keeps the earlier window on a tie
            if (cl > best_len_q) begin
              best_start_d = cs;
              best_len_d   = cl;
            end
          end else begin
            cur_len_d = '0;
          end
          if (IOD_OOR[lane_q]) oor_d = 1'b1;
          state_d = (IOD_OOR[lane_q] || (tap_q[lane_q] == TAP_MAX)) ? ST_CENTER : ST_STEP;
        end
        ST_STEP: begin
          move_d[lane_q] = 1'b1;
          dir_d[lane_q]  = 1'b1;
          tap_d[lane_q]  = tap_q[lane_q] + W'(1);
          state_d        = ST_CLR;
        end
        ST_CENTER: begin
          if (best_len_q >= MIN_WIN) begin
            if (tap_q[lane_q] != target) begin
              move_d[lane_q] = 1'b1;
              dir_d[lane_q]  = 1'b0;
              tap_d[lane_q]  = tap_q[lane_q] - W'(1);
            end else begin
`ifdef RX_ALGN_TRACK_EN
              center_d[lane_q] = tap_q[lane_q];
`endif
              state_d = ST_NEXT_LANE;
            end
          end else begin
            err_lane_d[lane_q] = 1'b1;
            load_d[lane_q]     = 1'b1;
            tap_d[lane_q]      = '0;
            state_d            = ST_NEXT_LANE;
          end
        end
        ST_NEXT_LANE: begin
          if (lane_q == LAST_LANE) begin
            lane_d  = '0;
            state_d = ST_DONE;
          end else begin
            lane_d  = lane_q + LW'(1);
            state_d = ST_LOAD;
          end
        end
        ST_DONE: begin
          if (ALGN_RSTRT) begin
            lane_d     = '0;
            err_lane_d = '0;
            oor_d      = 1'b0;
            state_d    = ST_LOAD;
`ifdef RX_ALGN_TRACK_EN
            trk_lane_d = LAST_LANE;
            trk_ph_d   = '0;
`endif
          end else begin
`ifdef RX_ALGN_TRACK_EN
            // round-robin over passing lanes: clear flags, settle, then nudge within +/-2 of centre
            case (trk_ph_q)
              2'd0: begin
                for (int i = 0; i < int'(NUM_LANES); i++) begin
                  idx = (idx == LAST_LANE) ? '0 : idx + LW'(1);
                  if (!found && !err_lane_q[idx]) begin
                    nl    = idx;
                    found = 1'b1;
                  end
                end
                if (found) begin
                  trk_lane_d = nl;
                  clr_d[nl]  = 1'b1;
                  wait_d     = '0;
                  trk_ph_d   = 2'd1;
                end
              end
              2'd1: begin
                if (wait_q == '1) trk_ph_d = 2'd2;
                else              wait_d   = wait_q + SW'(1);
              end
              default: begin
                if (IOD_EARLY[trk_lane_q] && !IOD_LATE[trk_lane_q] &&
                    (t_ext < c_ext + WW'(2)) && (tap_q[trk_lane_q] != TAP_MAX)) begin
                  move_d[trk_lane_q] = 1'b1;
                  dir_d[trk_lane_q]  = 1'b1;
                  tap_d[trk_lane_q]  = tap_q[trk_lane_q] + W'(1);
                end else if (IOD_LATE[trk_lane_q] && !IOD_EARLY[trk_lane_q] &&
                             (t_ext + WW'(2) > c_ext) && (tap_q[trk_lane_q] != '0)) begin
                  move_d[trk_lane_q] = 1'b1;
                  dir_d[trk_lane_q]  = 1'b0;
                  tap_d[trk_lane_q]  = tap_q[trk_lane_q] - W'(1);
                end
                trk_ph_d = 2'd0;
              end
            endcase
`endif
          end
        end
        default: state_d = ST_WAIT_LOCK;
      endcase
    end

    start_d = (state_d != ST_WAIT_LOCK) && (state_d != ST_DONE);
    done_d  = (state_d == ST_DONE);
    err_d   = done_d && (|err_lane_d);
  end

  // State and registered outputs; taps survive lock loss but not reset.
  always_ff @(posedge SCLK) begin
    if (RESET) begin
      state_q      <= ST_WAIT_LOCK;
      lane_q       <= '0;
      lock_q       <= 1'b0;
      wait_q       <= '0;
      tap_q        <= '0;
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
      clr_q        <= '0;
      load_q       <= '0;
      move_q       <= '0;
      dir_q        <= '0;
      err_lane_q   <= '0;
      oor_q        <= 1'b0;
      start_q      <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef RX_ALGN_TRACK_EN
      center_q     <= '0;
      trk_lane_q   <= LAST_LANE;
      trk_ph_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      lock_q       <= lock_d;
      wait_q       <= wait_d;
      tap_q        <= tap_d;
      cur_start_q  <= cur_start_d;
      cur_len_q    <= cur_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      clr_q        <= clr_d;
      load_q       <= load_d;
      move_q       <= move_d;
      dir_q        <= dir_d;
      err_lane_q   <= err_lane_d;
      oor_q        <= oor_d;
      start_q      <= start_d;
      done_q       <= done_d;
      err_q        <= err_d;
`ifdef RX_ALGN_TRACK_EN
      center_q     <= center_d;
      trk_lane_q   <= trk_lane_d;
      trk_ph_q     <= trk_ph_d;
`endif
    end
  end

  assign ALGN_CLR_FLGS = clr_q;
  assign ALGN_LOAD     = load_q;
  assign ALGN_MOVE     = move_q;
  assign ALGN_DIR      = dir_q;
  assign LANE_TAPDLY   = tap_q;
  assign ALGN_START    = start_q;
  assign ALGN_DONE     = done_q;
  assign ALGN_ERR      = err_q;
  assign ALGN_ERR_LANE = err_lane_q;
  assign ALGN_OOR      = oor_q;

endmodule
